// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizing for the pulse sequencer slice.
package pulse_seq_pkg;

   localparam int N_CH_DEF = 4;
   localparam int W_DEF    = 32;
   localparam int CW_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN
   } state_t;

endpackage

// File: rtl/pulse_seq_window.sv
// One channel's window decode: high while delay <= pc < delay+width.
// The end bound is formed one bit wider so it cannot wrap.
module pulse_seq_window
   import pulse_seq_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] delay,
   input  logic [W-1:0] width,
   input  logic [W-1:0] pc,
   output logic         hit
);

   logic [W:0] stop;

   assign stop = {1'b0, delay} + {1'b0, width};
   assign hit  = (pc >= delay) && ({1'b0, pc} < stop);

endmodule

// File: rtl/pulse_sequencer.sv
// Burst controller: validates and latches config on arm, runs count periods
// after a trigger edge, and drives each channel's start level inside its window.
module pulse_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int W    = W_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig,
   input  logic [W-1:0]      period,
   input  logic [CW-1:0]     count,
   input  logic [N_CH*W-1:0] delay,
   input  logic [N_CH*W-1:0] width,
   output logic [N_CH-1:0]   start_o,
   output logic [N_CH*W-1:0] duration_o,
   output logic              busy,
   output logic              done,
   output logic              err_cfg
);

   state_t state, state_n;

   logic [W-1:0]      pc, pc_n;
   logic [CW-1:0]     bc, bc_n;
   logic              trig_q;
   logic [W-1:0]      period_q;
   logic [CW-1:0]     count_q;
   logic [N_CH*W-1:0] delay_q;
   logic [N_CH*W-1:0] width_q;
   logic              cfg_bad;
   logic              accept;
   logic              done_n;
   logic              err_n;
   logic [N_CH-1:0]   hit;

   always_comb begin
      cfg_bad = (period == '0) || (count == '0);
      for (int i = 0; i < N_CH; i++) begin
         if (({1'b0, delay[i*W +: W]} + {1'b0, width[i*W +: W]}) > {1'b0, period}) begin
            cfg_bad = 1'b1;
         end
      end
   end

   // Abort wins over every other event; the last wrap of the burst ends in IDLE.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      bc_n    = bc;
      accept  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (abort) begin
         state_n = IDLE;
         pc_n    = '0;
         bc_n    = '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  if (cfg_bad) begin
                     err_n = 1'b1;
                  end else begin
                     accept  = 1'b1;
                     state_n = ARMED;
                  end
               end
            end
            ARMED: begin
               if (trig && !trig_q) begin
                  state_n = RUN;
                  pc_n    = '0;
                  bc_n    = '0;
               end
            end
            RUN: begin
               if (pc == period_q - W'(1)) begin
                  pc_n = '0;
                  if (bc + CW'(1) == count_q) begin
                     state_n = IDLE;
                     bc_n    = '0;
                     done_n  = 1'b1;
                  end else begin
                     bc_n = bc + CW'(1);
                  end
               end else begin
                  pc_n = pc + W'(1);
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_win
      pulse_seq_window #(.W(W)) u_win (
         .delay (delay_q[i*W +: W]),
         .width (width_q[i*W +: W]),
         .pc    (pc_n),
         .hit   (hit[i])
      );
   end

   // Windows are decoded from next-cycle pc so start_o lines up with the registered pc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         bc       <= '0;
         trig_q   <= 1'b0;
         period_q <= '0;
         count_q  <= '0;
         delay_q  <= '0;
         width_q  <= '0;
         start_o  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_cfg  <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         bc      <= bc_n;
         trig_q  <= trig;
         start_o <= (state_n == RUN) ? hit : '0;
         busy    <= (state_n != IDLE);
         done    <= done_n;
         err_cfg <= err_n;
         if (accept) begin
            period_q <= period;
            count_q  <= count;
            delay_q  <= delay;
            width_q  <= width;
         end
      end
   end

   assign duration_o = width_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: bursts, rejected configs, abort,
// ignored mid-burst requests, boundary windows and asynchronous reset.
module tb_pulse_sequencer;

   localparam int N_CH = 4;
   localparam int W    = 32;
   localparam int CW   = 16;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic              arm   = 1'b0;
   logic              abort = 1'b0;
   logic              trig  = 1'b0;
   logic [W-1:0]      period = '0;
   logic [CW-1:0]     count  = '0;
   logic [N_CH*W-1:0] delay  = '0;
   logic [N_CH*W-1:0] width  = '0;
   logic [N_CH-1:0]   start_o;
   logic [N_CH*W-1:0] duration_o;
   logic              busy;
   logic              done;
   logic              err_cfg;

   int total = 0;
   int bad   = 0;

   pulse_sequencer #(.N_CH(N_CH), .W(W), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .abort      (abort),
      .trig       (trig),
      .period     (period),
      .count      (count),
      .delay      (delay),
      .width      (width),
      .start_o    (start_o),
      .duration_o (duration_o),
      .busy       (busy),
      .done       (done),
      .err_cfg    (err_cfg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [W-1:0] p, input logic [CW-1:0] c,
                          input logic [N_CH*W-1:0] d, input logic [N_CH*W-1:0] w);
      period = p;
      count  = c;
      delay  = d;
      width  = w;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   // Leaves the bench in the first RUN cycle (T+1) of an accepted trigger.
   task automatic do_trig();
      trig = 1'b1;
      step();
      trig = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      step();
      step();
      total++;
      if ({start_o, busy, done, err_cfg} !== 7'b0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl got=%b want=0", {start_o, busy, done, err_cfg});
      end
      total++;
      if (duration_o !== '0) begin
         bad++;
         $display("[TB] FAIL reset_duration got=%h want=0", duration_o);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [N_CH-1:0] exp_s;
      int p;
      set_cfg(32'd10, 16'd2, {32'd0, 32'd5, 32'd0, 32'd2}, {32'd10, 32'd5, 32'd0, 32'd3});
      do_arm();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_armed_busy got=%b want=1", busy);
      end
      total++;
      if (duration_o !== {32'd10, 32'd5, 32'd0, 32'd3}) begin
         bad++;
         $display("[TB] FAIL basic_duration got=%h want=%h", duration_o, {32'd10, 32'd5, 32'd0, 32'd3});
      end
      do_trig();
      for (int k = 1; k <= 22; k++) begin
         if (k > 1) step();
         p = (k - 1) % 10;
         exp_s = (k <= 20) ? {1'b1, (p >= 5), 1'b0, (p >= 2 && p < 5)} : 4'b0000;
         total++;
         if (start_o !== exp_s) begin
            bad++;
            $display("[TB] FAIL basic_start k=%0d got=%b want=%b", k, start_o, exp_s);
         end
         total++;
         if (done !== (k == 21)) begin
            bad++;
            $display("[TB] FAIL basic_done k=%0d got=%b want=%b", k, done, (k == 21));
         end
         total++;
         if (busy !== (k <= 20)) begin
            bad++;
            $display("[TB] FAIL basic_busy k=%0d got=%b want=%b", k, busy, (k <= 20));
         end
      end
   endtask

   task automatic test_err_cfg();
      logic [N_CH*W-1:0] prev_dur;
      prev_dur = {32'd10, 32'd5, 32'd0, 32'd3};
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: set_cfg(32'd8, 16'd1, {96'd0, 32'd6}, {96'd0, 32'd3});
            1: set_cfg(32'd0, 16'd1, '0, '0);
            2: set_cfg(32'd10, 16'd0, '0, {96'd0, 32'd2});
            default: set_cfg(32'd10, 16'd1, {32'hFFFF_FFFF, 96'd0}, {32'd2, 96'd0});
         endcase
         do_arm();
         total++;
         if (err_cfg !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_pulse case=%0d got err/busy/done=%b%b%b want=100", c, err_cfg, busy, done);
         end
         step();
         total++;
         if (err_cfg !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_after case=%0d got err/busy=%b%b want=00", c, err_cfg, busy);
         end
         total++;
         if (duration_o !== prev_dur) begin
            bad++;
            $display("[TB] FAIL err_duration case=%0d got=%h want=%h", c, duration_o, prev_dur);
         end
      end
      do_trig();
      step();
      total++;
      if (busy !== 1'b0 || start_o !== 4'b0) begin
         bad++;
         $display("[TB] FAIL err_trig_idle got busy/start=%b/%b want 0/0000", busy, start_o);
      end
   endtask

   task automatic test_abort();
      int done_seen;
      set_cfg(32'd10, 16'd3, '0, {96'd0, 32'd8});
      do_arm();
      do_trig();
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) step();
         total++;
         if (start_o !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL abort_pre k=%0d got=%b want=0001", k, start_o);
         end
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++;
      if (start_o !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_next got start/busy/done=%b/%b/%b want 0000/0/0", start_o, busy, done);
      end
      done_seen = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      total++;
      if (done_seen !== 0) begin
         bad++;
         $display("[TB] FAIL abort_quiet got=%0d active cycles want=0", done_seen);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_s;
      int p;
      set_cfg(32'd10, 16'd2, '0, {96'd0, 32'd3});
      delay = {96'd0, 32'd2};
      do_arm();
      do_trig();
      for (int k = 1; k <= 22; k++) begin
         if (k > 1) step();
         p = (k - 1) % 10;
         exp_s = (k <= 20) && (p >= 2) && (p < 5);
         total++;
         if (start_o[0] !== exp_s || done !== (k == 21) || busy !== (k <= 20)) begin
            bad++;
            $display("[TB] FAIL b2b_burst k=%0d got start0/done/busy=%b%b%b want=%b%b%b",
                     k, start_o[0], done, busy, exp_s, (k == 21), (k <= 20));
         end
         if (k == 4) trig = 1'b1;
         if (k == 6) trig = 1'b0;
         if (k == 7) begin
            set_cfg(32'd4, 16'd1, '0, {96'd0, 32'd1});
            arm = 1'b1;
         end
         if (k == 8) arm = 1'b0;
      end
      total++;
      if (duration_o !== {96'd0, 32'd3}) begin
         bad++;
         $display("[TB] FAIL b2b_duration got=%h want=%h", duration_o, {96'd0, 32'd3});
      end
      do_trig();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_not_armed got busy=%b want=0", busy);
      end
   endtask

   task automatic test_count_one();
      set_cfg(32'd10, 16'd1, '0, {96'd0, 32'd10});
      do_arm();
      do_trig();
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) step();
         total++;
         if (start_o !== ((k <= 10) ? 4'b0001 : 4'b0000) || done !== (k == 11) || busy !== (k <= 10)) begin
            bad++;
            $display("[TB] FAIL count1 k=%0d got start/done/busy=%b/%b/%b want=%b/%b/%b",
                     k, start_o, done, busy, ((k <= 10) ? 4'b0001 : 4'b0000), (k == 11), (k <= 10));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic exp_s;
      set_cfg(32'd10, 16'd2, {96'd0, 32'd2}, {96'd0, 32'd3});
      do_arm();
      do_trig();
      step();
      step();
      total++;
      if (start_o !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rstmid_pre got=%b want=0001", start_o);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({start_o, busy, done, err_cfg} !== 7'b0 || duration_o !== '0) begin
         bad++;
         $display("[TB] FAIL rstmid_async got ctrl=%b dur=%h want 0/0", {start_o, busy, done, err_cfg}, duration_o);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      set_cfg(32'd5, 16'd1, {96'd0, 32'd1}, {96'd0, 32'd2});
      do_arm();
      total++;
      if (duration_o !== {96'd0, 32'd2} || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstmid_rearm got dur=%h busy=%b want %h 1", duration_o, busy, {96'd0, 32'd2});
      end
      do_trig();
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) step();
         exp_s = (k == 2) || (k == 3);
         total++;
         if (start_o[0] !== exp_s || done !== (k == 6) || busy !== (k <= 5)) begin
            bad++;
            $display("[TB] FAIL rstmid_burst k=%0d got start0/done/busy=%b%b%b want=%b%b%b",
                     k, start_o[0], done, busy, exp_s, (k == 6), (k <= 5));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_err_cfg();
      test_abort();
      test_back_to_back();
      test_count_one();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
